// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: turns EXU load/store requests into valid/ready memory
// transactions, with alignment checks, byte-lane steering, load extension and a response timeout.
module lsu_mem_ctrl #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [2:0]        req_size,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_wen,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [XLEN/8-1:0] mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata,
   input  logic              mem_rsp_err
);

   localparam int unsigned STRB_W = XLEN / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

   state_e             state_q, state_d;
   logic               wen_q, wen_d;
   logic [OFF_W-1:0]   off_q, off_d;
   logic [2:0]         size_q, size_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               req_ready_q, req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]    resp_rdata_q, resp_rdata_d;
   logic               resp_err_q, resp_err_d;
   logic               mem_req_valid_q, mem_req_valid_d;
   logic               mem_req_wen_q, mem_req_wen_d;
   logic [XLEN-1:0]    mem_req_addr_q, mem_req_addr_d;
   logic [XLEN-1:0]    mem_req_wdata_q, mem_req_wdata_d;
   logic [STRB_W-1:0]  mem_req_wstrb_q, mem_req_wstrb_d;

   logic               misaligned_c;
   logic [STRB_W-1:0]  strb_base_c;
   logic [XLEN-1:0]    rsp_shift_c;
   logic [XLEN-1:0]    load_data_c;

   // Alignment rule: the access must sit on a multiple of its own size; funct3 7 is never legal.
   always_comb begin
      misaligned_c = 1'b0;
      case (req_size)
         3'd1, 3'd5: misaligned_c = req_addr[0];
         3'd2, 3'd6: misaligned_c = |req_addr[1:0];
         3'd3:       misaligned_c = |req_addr[OFF_W-1:0];
         3'd7:       misaligned_c = 1'b1;
         default:    misaligned_c = 1'b0;
      endcase
   end

   always_comb begin
      case (req_size[1:0])
         2'd0:    strb_base_c = STRB_W'(8'h01);
         2'd1:    strb_base_c = STRB_W'(8'h03);
         2'd2:    strb_base_c = STRB_W'(8'h0F);
         default: strb_base_c = STRB_W'(8'hFF);
      endcase
   end

   // Move the addressed lane down to bit 0, then extend to XLEN.
   always_comb begin
      rsp_shift_c = mem_rsp_rdata >> {off_q, 3'b000};
      case (size_q)
         3'd0:    load_data_c = {{(XLEN-8){rsp_shift_c[7]}},   rsp_shift_c[7:0]};
         3'd1:    load_data_c = {{(XLEN-16){rsp_shift_c[15]}}, rsp_shift_c[15:0]};
         3'd2:    load_data_c = {{(XLEN-32){rsp_shift_c[31]}}, rsp_shift_c[31:0]};
         3'd4:    load_data_c = {{(XLEN-8){1'b0}},  rsp_shift_c[7:0]};
         3'd5:    load_data_c = {{(XLEN-16){1'b0}}, rsp_shift_c[15:0]};
         3'd6:    load_data_c = {{(XLEN-32){1'b0}}, rsp_shift_c[31:0]};
         default: load_data_c = rsp_shift_c;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      wen_d           = wen_q;
      off_d           = off_q;
      size_d          = size_q;
      cnt_d           = cnt_q;
      req_ready_d     = req_ready_q;
      resp_valid_d    = resp_valid_q;
      resp_rdata_d    = resp_rdata_q;
      resp_err_d      = resp_err_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_req_wen_d   = mem_req_wen_q;
      mem_req_addr_d  = mem_req_addr_q;
      mem_req_wdata_d = mem_req_wdata_q;
      mem_req_wstrb_d = mem_req_wstrb_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               wen_d       = req_wen;
               off_d       = req_addr[OFF_W-1:0];
               size_d      = req_size;
               if (misaligned_c) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d         = REQ;
                  mem_req_valid_d = 1'b1;
                  mem_req_wen_d   = req_wen;
                  mem_req_addr_d  = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                  mem_req_wdata_d = req_wdata << {req_addr[OFF_W-1:0], 3'b000};
                  mem_req_wstrb_d = req_wen ? (strb_base_c << req_addr[OFF_W-1:0]) : '0;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               state_d         = WAIT;
               cnt_d           = '0;
               mem_req_valid_d = 1'b0;
               mem_req_wen_d   = 1'b0;
               mem_req_addr_d  = '0;
               mem_req_wdata_d = '0;
               mem_req_wstrb_d = '0;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A real response wins over a timeout landing in the same cycle.
            if (mem_rsp_valid) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = mem_rsp_err;
               resp_rdata_d = (wen_q || mem_rsp_err) ? '0 : load_data_c;
            end else if ((TIMEOUT_CYC != 0) && (cnt_d == CNT_W'(TIMEOUT_CYC))) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = '0;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               req_ready_d  = 1'b1;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         wen_q           <= 1'b0;
         off_q           <= '0;
         size_q          <= '0;
         cnt_q           <= '0;
         req_ready_q     <= 1'b0;
         resp_valid_q    <= 1'b0;
         resp_rdata_q    <= '0;
         resp_err_q      <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_req_wen_q   <= 1'b0;
         mem_req_addr_q  <= '0;
         mem_req_wdata_q <= '0;
         mem_req_wstrb_q <= '0;
      end else begin
         state_q         <= state_d;
         wen_q           <= wen_d;
         off_q           <= off_d;
         size_q          <= size_d;
         cnt_q           <= cnt_d;
         req_ready_q     <= req_ready_d;
         resp_valid_q    <= resp_valid_d;
         resp_rdata_q    <= resp_rdata_d;
         resp_err_q      <= resp_err_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_wen_q   <= mem_req_wen_d;
         mem_req_addr_q  <= mem_req_addr_d;
         mem_req_wdata_q <= mem_req_wdata_d;
         mem_req_wstrb_q <= mem_req_wstrb_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign resp_valid    = resp_valid_q;
   assign resp_rdata    = resp_rdata_q;
   assign resp_err      = resp_err_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_wen   = mem_req_wen_q;
   assign mem_req_addr  = mem_req_addr_q;
   assign mem_req_wdata = mem_req_wdata_q;
   assign mem_req_wstrb = mem_req_wstrb_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: the bench plays both EXU/WBU and memory, and predicts every
// response from the load/store rules with plain arithmetic.
module tb_lsu_mem_ctrl;

   localparam int unsigned TMO = 4;

   logic        clock, reset;
   logic        req_valid, req_ready, req_wen;
   logic [63:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_rsp_valid, mem_rsp_err;
   logic [63:0] mem_rsp_rdata;

   int checks = 0;
   int errors = 0;

   lsu_mem_ctrl #(.XLEN(64), .TIMEOUT_CYC(TMO)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .mem_rsp_err(mem_rsp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] size);
      return 1 << size[1:0];
   endfunction

   // Reference load result: pick nb bytes starting at byte off, extend to 64 bits.
   function automatic logic [63:0] load_model(input logic [63:0] d, input int off, input logic [2:0] size);
      logic [63:0] v, m;
      int nb;
      nb = nbytes(size);
      v  = d >> (8 * off);
      if (nb == 8) return v;
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!size[2] && v[8*nb-1]) v = v | ~m;
      return v;
   endfunction

   task automatic run_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [2:0] size, input int rdy_dly, input int lat,
                          input logic [63:0] rsp_data, input logic rsp_e, input int stall,
                          input logic junk_hs);
      int          nb, off, guard;
      logic        mis, exp_err;
      logic [63:0] exp_rd;
      logic [15:0] strb16;
      nb  = nbytes(size);
      off = int'(addr[2:0]);
      mis = (size == 3'd7) || ((off % nb) != 0);
      guard = 0;
      while (!req_ready && guard < 10) begin
         @(negedge clock);
         guard++;
      end
      chk("req_ready_idle", req_ready, 1);
      if (!req_ready) return;
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size;
      @(negedge clock);
      req_valid = 1'b0;
      chk("req_ready_busy", req_ready, 0);
      if (mis) begin
         exp_err = 1'b1;
         exp_rd  = '0;
         chk("mreq_valid_mis", mem_req_valid, 0);
      end else begin
         strb16 = ((16'd1 << nb) - 16'd1) << off;
         chk("mreq_valid", mem_req_valid, 1);
         chk("mreq_wen", mem_req_wen, wen);
         chk("mreq_addr", mem_req_addr, addr & ~64'd7);
         chk("mreq_wdata", mem_req_wdata, wdata << (8 * off));
         chk("mreq_wstrb", mem_req_wstrb, wen ? strb16[7:0] : 8'h00);
         repeat (rdy_dly) @(negedge clock);
         chk("mreq_hold", mem_req_valid, 1);
         chk("mreq_addr_hold", mem_req_addr, addr & ~64'd7);
         mem_req_ready = 1'b1;
         if (junk_hs) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = {$urandom(), $urandom()};
            mem_rsp_err   = 1'($urandom_range(0, 1));
         end
         @(negedge clock);
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
         chk("mreq_drop", mem_req_valid, 0);
         if (lat < int'(TMO)) begin
            repeat (lat) @(negedge clock);
            chk("resp_not_early", resp_valid, 0);
            mem_rsp_valid = 1'b1; mem_rsp_rdata = rsp_data; mem_rsp_err = rsp_e;
            @(negedge clock);
            mem_rsp_valid = 1'b0;
            exp_err = rsp_e;
            exp_rd  = (wen || rsp_e) ? 64'd0 : load_model(rsp_data, off, size);
         end else begin
            repeat (TMO - 1) @(negedge clock);
            chk("tmo_not_early", resp_valid, 0);
            @(negedge clock);
            exp_err = 1'b1;
            exp_rd  = '0;
            // late response must be ignored once the access has timed out
            mem_rsp_valid = 1'b1; mem_rsp_rdata = rsp_data | 64'h1; mem_rsp_err = 1'b0;
         end
      end
      chk("resp_valid", resp_valid, 1);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err", resp_err, exp_err);
      repeat (stall) begin
         @(negedge clock);
         mem_rsp_valid = 1'b0;
      end
      chk("resp_valid_hold", resp_valid, 1);
      chk("resp_rdata_hold", resp_rdata, exp_rd);
      chk("resp_err_hold", resp_err, exp_err);
      chk("req_ready_resp", req_ready, 0);
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      chk("resp_drop", resp_valid, 0);
      chk("req_ready_after", req_ready, 1);
   endtask

   initial begin
      logic [63:0] a;
      logic [2:0]  sz;
      int          nb;
      reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = '0; resp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_mreq_valid", mem_req_valid, 0);
      chk("rst_mreq_wstrb", mem_req_wstrb, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_ready", req_ready, 1);

      // LB, sign extension from byte 3
      run_txn(1'b0, 64'h1003, 64'h0, 3'd0, 0, 0, 64'h00000000_80000000, 1'b0, 0, 1'b0);
      // LWU from upper word
      run_txn(1'b0, 64'h2004, 64'h0, 3'd6, 0, 0, 64'h89ABCDEF_00000000, 1'b0, 0, 1'b0);
      // SH to bytes 6-7
      run_txn(1'b1, 64'h3006, 64'hBEEF, 3'd1, 1, 1, 64'h0, 1'b0, 0, 1'b0);
      // LW misaligned
      run_txn(1'b0, 64'h4002, 64'h0, 3'd2, 0, 0, 64'h0, 1'b0, 0, 1'b0);
      // timeout, then late response ignored
      run_txn(1'b0, 64'h5000, 64'h0, 3'd3, 0, 6, 64'hDEAD_BEEF_0000_1234, 1'b0, 2, 1'b0);
      // response on last legal WAIT cycle, response in handshake cycle ignored, long stall
      run_txn(1'b0, 64'h6008, 64'h0, 3'd1, 2, 3, 64'h0000_0000_0000_8001, 1'b0, 5, 1'b1);
      // memory bus error on a load
      run_txn(1'b0, 64'h7000, 64'h0, 3'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0);

      // Reset in WAIT aborts the access
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000; req_size = 3'd3;
      @(negedge clock);
      req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clock);
      mem_req_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("wait_rst_resp_valid", resp_valid, 0);
      chk("wait_rst_mreq_valid", mem_req_valid, 0);
      chk("wait_rst_req_ready", req_ready, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("wait_rst_idle_ready", req_ready, 1);
      chk("wait_rst_no_resp", resp_valid, 0);

      for (int i = 0; i < 200; i++) begin
         a  = {$urandom(), $urandom()};
         sz = 3'($urandom_range(0, 7));
         nb = nbytes(sz);
         if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'(nb - 1);
         run_txn(1'($urandom_range(0, 1)), a, {$urandom(), $urandom()}, sz,
                 $urandom_range(0, 2), $urandom_range(0, 5), {$urandom(), $urandom()},
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
